// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared types and constants for the unified-memory port arbiter.
//   arb_state_t : arbiter FSM state (IDLE, BUSY_I, BUSY_D)
//   GNT_I/GNT_D : bit positions of the fetch/data lanes in request/grant vectors
//   MEM_LAT_DEF : default memory access latency in cycles
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    localparam int GNT_I = 0;
    localparam int GNT_D = 1;

    localparam int MEM_LAT_DEF = 2;

endpackage

// File: rtl/arb_rr2.sv
// arb_rr2: two-way round-robin arbiter with a last-grant pointer.
//   clk_i, rst_i : clock, asynchronous active-low reset
//   req_i        : requests, bit GNT_I = fetch, bit GNT_D = data
//   adv_i        : a grant is being taken this edge; pointer follows gnt_o
//   gnt_o        : one-hot grant (all zero when nothing requests)
module arb_rr2
    import cpu_mem_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       adv_i,
    output logic [1:0] gnt_o
);

    // 1 = data was granted last, 0 = fetch was granted last
    logic last_d_q;

    always_comb begin
        gnt_o = '0;
        unique case (req_i)
            2'b01:   gnt_o[GNT_I] = 1'b1;
            2'b10:   gnt_o[GNT_D] = 1'b1;
            2'b11: begin
                // tie: favour whoever did not win last time
                if (last_d_q) gnt_o[GNT_I] = 1'b1;
                else          gnt_o[GNT_D] = 1'b1;
            end
            default: gnt_o = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            last_d_q <= 1'b0;
        else if (adv_i && (|req_i))
            last_d_q <= gnt_o[GNT_D];
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// and the data-memory stage. One access at a time, round-robin on ties,
// fixed MEM_LAT access latency, one-cycle ack pulses and a pipeline stall.
//   clk_i, rst_i                  : clock, asynchronous active-low reset
//   if_req_i/if_addr_i            : fetch request and address
//   if_ack_o/if_rdata_o           : fetch completion pulse and instruction
//   dm_req_i/dm_we_i/dm_addr_i/dm_wdata_i : data request
//   dm_ack_o/dm_rdata_o           : data completion pulse and read data
//   stall_o                       : freeze while any request is unacknowledged
//   mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_rdata_i : memory port
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_ack_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              stall_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
        $error("mem_port_arbiter: MEM_LAT must be in 1..15");
    end

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              if_ack_q, if_ack_d, dm_ack_q, dm_ack_d;
    logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;

    logic       req_i_m, req_d_m, last_edge, grant;
    logic [1:0] arb_req, gnt;

    // A requester whose ack is showing this cycle is still holding req from
    // the finished access; it must not be granted again on the same request.
    assign req_i_m   = if_req_i & ~if_ack_q;
    assign req_d_m   = dm_req_i & ~dm_ack_q;
    assign last_edge = (state_q != IDLE) && (cnt_q == CNT_W'(1));

    // On the completing edge only the other requester may be handed the
    // port, which lets back-to-back I/D traffic run without an idle edge.
    always_comb begin
        arb_req = '0;
        unique case (state_q)
            IDLE: begin
                arb_req[GNT_I] = req_i_m;
                arb_req[GNT_D] = req_d_m;
            end
            BUSY_I:  arb_req[GNT_D] = req_d_m & last_edge;
            BUSY_D:  arb_req[GNT_I] = req_i_m & last_edge;
            default: arb_req = '0;
        endcase
    end

    assign grant = |arb_req;

    arb_rr2 u_rr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (arb_req),
        .adv_i (grant),
        .gnt_o (gnt)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (gnt[GNT_I]) begin
            state_d = BUSY_I;
            cnt_d   = CNT_W'(MEM_LAT);
        end else if (gnt[GNT_D]) begin
            state_d = BUSY_D;
            cnt_d   = CNT_W'(MEM_LAT);
        end else if (state_q != IDLE) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (last_edge) state_d = IDLE;
        end
    end

    // Output-register logic
    always_comb begin
        mem_en_d    = grant;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (gnt[GNT_I]) begin
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr_i;
            mem_wdata_d = '0;
        end else if (gnt[GNT_D]) begin
            mem_we_d    = dm_we_i;
            mem_addr_d  = dm_addr_i;
            mem_wdata_d = dm_wdata_i;
        end
        if_ack_d   = last_edge && (state_q == BUSY_I);
        dm_ack_d   = last_edge && (state_q == BUSY_D);
        // mem_we_q still describes the finishing access here, even when a
        // hand-off grant is loading the next one at the same edge.
        if_rdata_d = if_ack_d ? mem_rdata_i : if_rdata_q;
        dm_rdata_d = (dm_ack_d && !mem_we_q) ? mem_rdata_i : dm_rdata_q;
    end

    assign if_ack_o    = if_ack_q;
    assign dm_ack_o    = dm_ack_q;
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    // Held low in reset so every output reads 0 while rst_i is asserted.
    assign stall_o     = rst_i & (req_i_m | req_d_m);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter. DUT a runs with
// MEM_LAT=2, DUT b with MEM_LAT=1; each has a combinational memory model.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // DUT a (MEM_LAT=2)
    logic        a_if_req, a_dm_req, a_dm_we;
    logic [31:0] a_if_addr, a_dm_addr, a_dm_wdata;
    logic        a_if_ack, a_dm_ack, a_stall, a_mem_en, a_mem_we;
    logic [31:0] a_if_rdata, a_dm_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;

    // DUT b (MEM_LAT=1)
    logic        b_if_req, b_dm_req, b_dm_we;
    logic [31:0] b_if_addr, b_dm_addr, b_dm_wdata;
    logic        b_if_ack, b_dm_ack, b_stall, b_mem_en, b_mem_we;
    logic [31:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h40) return 32'h8C01_0004;
        return {16'hA5A5, a[15:0]};
    endfunction

    assign a_mem_rdata = mem_f(a_mem_addr);
    assign b_mem_rdata = (b_mem_addr == 32'h500) ? 32'hDEAD_BEEF : 32'h0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u_a (
        .clk_i(clk), .rst_i(rst_n),
        .if_req_i(a_if_req), .if_addr_i(a_if_addr), .if_ack_o(a_if_ack), .if_rdata_o(a_if_rdata),
        .dm_req_i(a_dm_req), .dm_we_i(a_dm_we), .dm_addr_i(a_dm_addr), .dm_wdata_i(a_dm_wdata),
        .dm_ack_o(a_dm_ack), .dm_rdata_o(a_dm_rdata), .stall_o(a_stall),
        .mem_en_o(a_mem_en), .mem_we_o(a_mem_we), .mem_addr_o(a_mem_addr),
        .mem_wdata_o(a_mem_wdata), .mem_rdata_i(a_mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_b (
        .clk_i(clk), .rst_i(rst_n),
        .if_req_i(b_if_req), .if_addr_i(b_if_addr), .if_ack_o(b_if_ack), .if_rdata_o(b_if_rdata),
        .dm_req_i(b_dm_req), .dm_we_i(b_dm_we), .dm_addr_i(b_dm_addr), .dm_wdata_i(b_dm_wdata),
        .dm_ack_o(b_dm_ack), .dm_rdata_o(b_dm_rdata), .stall_o(b_stall),
        .mem_en_o(b_mem_en), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr),
        .mem_wdata_o(b_mem_wdata), .mem_rdata_i(b_mem_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_if_req = 0; a_dm_req = 0; a_dm_we = 0;
        a_if_addr = 0; a_dm_addr = 0; a_dm_wdata = 0;
        b_if_req = 0; b_dm_req = 0; b_dm_we = 0;
        b_if_addr = 0; b_dm_addr = 0; b_dm_wdata = 0;

        // reset state
        #1;
        chk("rst_if_ack",  a_if_ack, 0);
        chk("rst_dm_ack",  a_dm_ack, 0);
        chk("rst_mem_en",  a_mem_en, 0);
        chk("rst_mem_we",  a_mem_we, 0);
        chk("rst_addr",    a_mem_addr, 0);
        chk("rst_wdata",   a_mem_wdata, 0);
        chk("rst_stall",   a_stall, 0);
        chk("rst_if_rd",   a_if_rdata, 0);
        chk("rst_b_en",    b_mem_en, 0);
        tick(); tick();
        rst_n = 1'b1;

        // single fetch
        a_if_req = 1; a_if_addr = 32'h40;
        #1 chk("t1_stall_req", a_stall, 1);
        tick();
        chk("t1_en",    a_mem_en, 1);
        chk("t1_addr",  a_mem_addr, 32'h40);
        chk("t1_we",    a_mem_we, 0);
        chk("t1_ack0",  a_if_ack, 0);
        tick();
        chk("t1_en_off", a_mem_en, 0);
        chk("t1_ack1",   a_if_ack, 0);
        chk("t1_stall",  a_stall, 1);
        tick();
        chk("t1_ack",    a_if_ack, 1);
        chk("t1_rdata",  a_if_rdata, 32'h8C01_0004);
        chk("t1_stall_ack", a_stall, 0);
        a_if_req = 0;
        tick();
        chk("t1_ack_end", a_if_ack, 0);
        chk("t1_no_en",   a_mem_en, 0);
        chk("t1_hold",    a_if_rdata, 32'h8C01_0004);

        // simultaneous write + fetch: data wins first tie
        a_if_req = 1; a_if_addr = 32'h44;
        a_dm_req = 1; a_dm_we = 1; a_dm_addr = 32'h100; a_dm_wdata = 32'h1234;
        tick();
        chk("t2_en",    a_mem_en, 1);
        chk("t2_we",    a_mem_we, 1);
        chk("t2_addr",  a_mem_addr, 32'h100);
        chk("t2_wdata", a_mem_wdata, 32'h1234);
        tick();
        chk("t2_en_off", a_mem_en, 0);
        tick();
        chk("t2_dm_ack", a_dm_ack, 1);
        chk("t2_i_en",   a_mem_en, 1);
        chk("t2_i_addr", a_mem_addr, 32'h44);
        chk("t2_i_we",   a_mem_we, 0);
        chk("t2_dm_rd",  a_dm_rdata, 0);
        chk("t2_stall",  a_stall, 1);
        a_dm_req = 0;
        tick();
        chk("t2_dm_ack_end", a_dm_ack, 0);
        chk("t2_en_off2",    a_mem_en, 0);
        tick();
        chk("t2_if_ack",  a_if_ack, 1);
        chk("t2_if_rd",   a_if_rdata, 32'hA5A5_0044);
        chk("t2_dm_rd2",  a_dm_rdata, 0);
        a_if_req = 0;
        tick();
        chk("t2_if_ack_end", a_if_ack, 0);

        // continuous traffic: D, I, D, I ...
        a_if_req = 1; a_if_addr = 32'h48;
        a_dm_req = 1; a_dm_we = 0; a_dm_addr = 32'h200;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t3_en", a_mem_en, 1);
            chk("t3_addr", a_mem_addr, (k % 2 == 0) ? 32'h200 : 32'h48);
            if (k > 0) begin
                chk("t3_dm_ack", a_dm_ack, ((k - 1) % 2 == 0) ? 1 : 0);
                chk("t3_if_ack", a_if_ack, ((k - 1) % 2 == 1) ? 1 : 0);
            end
            if (k == 7) a_dm_req = 0;
            tick();
            chk("t3_en_off", a_mem_en, 0);
            chk("t3_acks",   {30'd0, a_dm_ack, a_if_ack}, 0);
        end
        tick();
        chk("t3_last_ack", a_if_ack, 1);
        chk("t3_last_dm",  a_dm_ack, 0);
        chk("t3_no_en",    a_mem_en, 0);
        chk("t3_if_rd",    a_if_rdata, 32'hA5A5_0048);
        chk("t3_dm_rd",    a_dm_rdata, 32'hA5A5_0200);
        a_if_req = 0;
        tick();
        chk("t3_idle_en",  a_mem_en, 0);
        chk("t3_idle_ack", a_if_ack, 0);
        chk("t3_stall",    a_stall, 0);

        // fetch dropped after grant (flush)
        a_if_req = 1; a_if_addr = 32'h4C;
        tick();
        chk("t4_en", a_mem_en, 1);
        a_if_req = 0;
        tick();
        chk("t4_stall", a_stall, 0);
        tick();
        chk("t4_ack",   a_if_ack, 1);
        chk("t4_rd",    a_if_rdata, 32'hA5A5_004C);
        tick();
        chk("t4_ack_end", a_if_ack, 0);
        chk("t4_no_en",   a_mem_en, 0);
        tick();
        chk("t4_no_en2",  a_mem_en, 0);

        // reset during a data read
        a_dm_req = 1; a_dm_we = 0; a_dm_addr = 32'h300;
        tick();
        chk("t5_en",   a_mem_en, 1);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_en",    a_mem_en, 0);
        chk("t5_rst_addr",  a_mem_addr, 0);
        chk("t5_rst_ack",   a_dm_ack, 0);
        chk("t5_rst_stall", a_stall, 0);
        chk("t5_rst_ifrd",  a_if_rdata, 0);
        chk("t5_rst_dmrd",  a_dm_rdata, 0);
        a_dm_req = 0;
        tick();
        chk("t5_no_ack", a_dm_ack, 0);
        rst_n = 1'b1;
        a_if_req = 1; a_if_addr = 32'h40;
        tick();
        chk("t5_f_en",   a_mem_en, 1);
        chk("t5_f_addr", a_mem_addr, 32'h40);
        tick();
        tick();
        chk("t5_f_ack",  a_if_ack, 1);
        chk("t5_f_rd",   a_if_rdata, 32'h8C01_0004);
        chk("t5_dm_ack", a_dm_ack, 0);
        a_if_req = 0;
        tick();
        chk("t5_f_end",  a_if_ack, 0);

        // MEM_LAT=1 read
        b_dm_req = 1; b_dm_we = 0; b_dm_addr = 32'h500;
        tick();
        chk("t6_en",   b_mem_en, 1);
        chk("t6_addr", b_mem_addr, 32'h500);
        chk("t6_ack0", b_dm_ack, 0);
        tick();
        chk("t6_ack",  b_dm_ack, 1);
        chk("t6_rd",   b_dm_rdata, 32'hDEAD_BEEF);
        b_dm_req = 0;
        tick();
        chk("t6_ack_end", b_dm_ack, 0);
        chk("t6_en_off",  b_mem_en, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
